// File: rtl/fft_pkg.sv
// Shared sizing, frame type and fill-state definitions for the FFT-to-point-stream converter.
package fft_pkg;

    localparam int N_BINS = 16;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 4;

    typedef logic [N_BINS-1:0][DATA_W-1:0] frame_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_BOTH
    } fill_state_t;

    // A load and a release in the same cycle cancel out and leave the fill level unchanged.
    function automatic fill_state_t fill_next(fill_state_t cur, logic load, logic rel);
        fill_state_t nxt;
        nxt = cur;
        case ({load, rel})
            2'b10: begin
                case (cur)
                    ST_EMPTY: nxt = ST_ONE;
                    ST_ONE:   nxt = ST_BOTH;
                    default:  nxt = ST_BOTH;
                endcase
            end
            2'b01: begin
                case (cur)
                    ST_BOTH: nxt = ST_ONE;
                    ST_ONE:  nxt = ST_EMPTY;
                    default: nxt = ST_EMPTY;
                endcase
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fft_pts_bank.sv
// One frame bank: 16 bins loaded in parallel, read back one bin at a time by index.
module pts_bank
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  frame_t            din,
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] dout
);

    // Contents are deliberately not reset; the owner's full flag hides stale data.
    frame_t mem;

    always_ff @(posedge clk) begin
        if (load) begin
            mem <= din;
        end
    end

    assign dout = mem[idx];

endmodule

// File: rtl/fft_pts.sv
// Double-buffered converter that takes a 16-bin FFT frame in one strobe and streams it bin by bin.
module fft_pts
    import fft_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              fft_valid,
    input  logic [DATA_W-1:0] fft_d0,
    input  logic [DATA_W-1:0] fft_d1,
    input  logic [DATA_W-1:0] fft_d2,
    input  logic [DATA_W-1:0] fft_d3,
    input  logic [DATA_W-1:0] fft_d4,
    input  logic [DATA_W-1:0] fft_d5,
    input  logic [DATA_W-1:0] fft_d6,
    input  logic [DATA_W-1:0] fft_d7,
    input  logic [DATA_W-1:0] fft_d8,
    input  logic [DATA_W-1:0] fft_d9,
    input  logic [DATA_W-1:0] fft_d10,
    input  logic [DATA_W-1:0] fft_d11,
    input  logic [DATA_W-1:0] fft_d12,
    input  logic [DATA_W-1:0] fft_d13,
    input  logic [DATA_W-1:0] fft_d14,
    input  logic [DATA_W-1:0] fft_d15,
    input  logic              out_ready,
    output logic              pts_valid,
    output logic [DATA_W-1:0] pts_d,
    output logic [IDX_W-1:0]  pts_idx,
    output logic              pts_last,
    output logic              overflow
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);

    frame_t            frame_in;
    logic [1:0]        full;
    logic [1:0]        full_next;
    logic              wr_sel;
    logic              rd_sel;
    logic [IDX_W-1:0]  rd_idx;
    logic              overflow_q;
    fill_state_t       state;
    fill_state_t       state_next;
    logic              handshake;
    logic              rel;
    logic              wr_free;
    logic              load;
    logic              drop;
    logic [DATA_W-1:0] dout_a;
    logic [DATA_W-1:0] dout_b;
    logic [DATA_W-1:0] rd_data;

    assign frame_in = {fft_d15, fft_d14, fft_d13, fft_d12, fft_d11, fft_d10, fft_d9, fft_d8,
                       fft_d7,  fft_d6,  fft_d5,  fft_d4,  fft_d3,  fft_d2,  fft_d1, fft_d0};

    pts_bank u_bank_a (
        .clk  (CLK),
        .load (load && !wr_sel),
        .din  (frame_in),
        .idx  (rd_idx),
        .dout (dout_a)
    );

    pts_bank u_bank_b (
        .clk  (CLK),
        .load (load && wr_sel),
        .din  (frame_in),
        .idx  (rd_idx),
        .dout (dout_b)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // The bank being drained on its final bin counts as free, so a new frame can land there the same edge.
    always_comb begin
        handshake  = 1'b0;
        rel        = 1'b0;
        wr_free    = 1'b0;
        load       = 1'b0;
        drop       = 1'b0;
        full_next  = full;
        state_next = state;

        handshake = full[rd_sel] && out_ready;
        rel       = handshake && (rd_idx == LAST_IDX);
        wr_free   = !full[wr_sel] || (rel && (rd_sel == wr_sel));
        load      = fft_valid && wr_free;
        drop      = fft_valid && !wr_free;

        if (rel) begin
            full_next[rd_sel] = 1'b0;
        end
        if (load) begin
            full_next[wr_sel] = 1'b1;
        end

        state_next = fill_next(state, load, rel);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            full       <= 2'b00;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            rd_idx     <= '0;
            overflow_q <= 1'b0;
        end else begin
            full <= full_next;
            if (load) begin
                wr_sel <= !wr_sel;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (handshake) begin
                if (rd_idx == LAST_IDX) begin
                    rd_idx <= '0;
                    rd_sel <= !rd_sel;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end
        end
    end

    assign rd_data   = rd_sel ? dout_b : dout_a;
    assign pts_valid = full[rd_sel];
    // Gating keeps the unreset bank contents from appearing on the output while nothing is valid.
    assign pts_d     = pts_valid ? rd_data : '0;
    assign pts_idx   = rd_idx;
    assign pts_last  = pts_valid && (rd_idx == LAST_IDX);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_pts.sv
// Self-checking bench for fft_pts: frame-queue reference model plus directed scenarios.
module tb_fft_pts;

    typedef logic [15:0][31:0] tb_frame_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        fft_valid = 1'b0;
    logic        out_ready = 1'b0;
    tb_frame_t   din = '0;
    logic        pts_valid;
    logic [31:0] pts_d;
    logic [3:0]  pts_idx;
    logic        pts_last;
    logic        overflow;

    int nCompared = 0;
    int nMismatched = 0;

    // Reference model: a FIFO of at most two accepted frames and the position within the head frame.
    tb_frame_t modelQ[$];
    int        modelPos = 0;
    logic      modelOvf = 1'b0;
    logic      expValid;

    always #5 CLK = ~CLK;

    fft_pts dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .fft_valid (fft_valid),
        .fft_d0    (din[0]),
        .fft_d1    (din[1]),
        .fft_d2    (din[2]),
        .fft_d3    (din[3]),
        .fft_d4    (din[4]),
        .fft_d5    (din[5]),
        .fft_d6    (din[6]),
        .fft_d7    (din[7]),
        .fft_d8    (din[8]),
        .fft_d9    (din[9]),
        .fft_d10   (din[10]),
        .fft_d11   (din[11]),
        .fft_d12   (din[12]),
        .fft_d13   (din[13]),
        .fft_d14   (din[14]),
        .fft_d15   (din[15]),
        .out_ready (out_ready),
        .pts_valid (pts_valid),
        .pts_d     (pts_d),
        .pts_idx   (pts_idx),
        .pts_last  (pts_last),
        .overflow  (overflow)
    );

    function automatic logic [31:0] frameWord(int f, int k);
        logic [15:0] v;
        if (f == 0) begin
            return {16'(k), 16'(-k)};
        end
        v = 16'(f * 16 + k);
        return {v, ~v};
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic loadFrame(int f);
        for (int k = 0; k < 16; k++) begin
            din[k] = frameWord(f, k);
        end
    endtask

    task automatic applyStimulus(int f);
        loadFrame(f);
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
    endtask

    // Model update: pop on the final accepted bin, push when space exists (counting a bin freed this edge).
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            modelQ.delete();
            modelPos = 0;
            modelOvf = 1'b0;
        end else begin
            bit hs;
            bit rl;
            bit acc;
            hs  = (modelQ.size() > 0) && out_ready;
            rl  = hs && (modelPos == 15);
            acc = fft_valid && ((modelQ.size() < 2) || rl);
            if (fft_valid && !acc) modelOvf = 1'b1;
            if (hs) modelPos = rl ? 0 : modelPos + 1;
            if (rl) void'(modelQ.pop_front());
            if (acc) modelQ.push_back(din);
        end
    end

    always @(negedge CLK) begin
        expValid = modelQ.size() > 0;
        checkOutput("pts_valid", 32'(pts_valid), 32'(expValid));
        checkOutput("pts_idx", 32'(pts_idx), 32'(modelPos));
        checkOutput("pts_last", 32'(pts_last), 32'(expValid && modelPos == 15));
        checkOutput("overflow", 32'(overflow), 32'(modelOvf));
        if (expValid) begin
            checkOutput("pts_d", pts_d, modelQ[0][modelPos]);
        end else if (!RST_N) begin
            checkOutput("pts_d_reset", pts_d, 32'h0);
        end
    end

    initial begin
        int cnt;
        int firstV;
        int lastV;

        // Reset values
        #1 RST_N = 1'b0;
        #1;
        checkOutput("reset_valid", 32'(pts_valid), 32'h0);
        checkOutput("reset_d", pts_d, 32'h0);
        checkOutput("reset_idx", 32'(pts_idx), 32'h0);
        checkOutput("reset_ovf", 32'(overflow), 32'h0);
        tick();
        tick();
        RST_N = 1'b1;
        tick();

        // Single frame with bins {k, -k}
        out_ready = 1'b1;
        applyStimulus(0);
        checkOutput("single_first_valid", 32'(pts_valid), 32'h1);
        checkOutput("single_first_d", pts_d, 32'h0000_0000);
        repeat (5) tick();
        checkOutput("single_idx5", 32'(pts_idx), 32'd5);
        checkOutput("single_d5", pts_d, 32'h0005_FFFB);
        repeat (10) tick();
        checkOutput("single_last", 32'(pts_last), 32'h1);
        checkOutput("single_d15", pts_d, 32'h000F_FFF1);
        tick();
        checkOutput("single_done", 32'(pts_valid), 32'h0);
        repeat (3) tick();

        // Two frames three cycles apart stream contiguously
        applyStimulus(1);
        cnt = 0;
        firstV = -1;
        lastV = -1;
        for (int c = 0; c < 40; c++) begin
            if (pts_valid) begin
                cnt++;
                if (firstV < 0) firstV = c;
                lastV = c;
            end
            if (c == 2) begin
                loadFrame(2);
                fft_valid = 1'b1;
            end
            tick();
            fft_valid = 1'b0;
        end
        checkOutput("two_count", 32'(cnt), 32'd32);
        checkOutput("two_span", 32'(lastV - firstV + 1), 32'd32);
        checkOutput("two_ovf", 32'(overflow), 32'h0);

        // Three back-to-back frames while stalled: third is dropped
        out_ready = 1'b0;
        applyStimulus(3);
        applyStimulus(4);
        applyStimulus(5);
        tick();
        checkOutput("drop_ovf", 32'(overflow), 32'h1);
        checkOutput("drop_head", pts_d, frameWord(3, 0));
        out_ready = 1'b1;
        repeat (40) tick();
        checkOutput("drop_drained", 32'(pts_valid), 32'h0);
        checkOutput("drop_ovf_sticky", 32'(overflow), 32'h1);
        RST_N = 1'b0;
        #3 RST_N = 1'b1;
        tick();

        // Load lands on the cycle the full bank releases its last bin
        out_ready = 1'b0;
        applyStimulus(6);
        applyStimulus(7);
        out_ready = 1'b1;
        repeat (15) tick();
        checkOutput("free_idx15", 32'(pts_idx), 32'd15);
        loadFrame(8);
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
        checkOutput("free_next_head", pts_d, frameWord(7, 0));
        repeat (40) tick();
        checkOutput("free_ovf", 32'(overflow), 32'h0);

        // Ready toggling every cycle
        out_ready = 1'b0;
        applyStimulus(9);
        for (int c = 0; c < 40; c++) begin
            out_ready = ~out_ready;
            tick();
        end
        checkOutput("toggle_drained", 32'(pts_valid), 32'h0);

        // Reset in the middle of a frame
        out_ready = 1'b1;
        applyStimulus(10);
        repeat (7) tick();
        checkOutput("midrst_idx7", 32'(pts_idx), 32'd7);
        #2 RST_N = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(pts_valid), 32'h0);
        checkOutput("midrst_d", pts_d, 32'h0);
        checkOutput("midrst_idx", 32'(pts_idx), 32'h0);
        checkOutput("midrst_last", 32'(pts_last), 32'h0);
        tick();
        RST_N = 1'b1;
        tick();
        applyStimulus(11);
        checkOutput("postrst_idx", 32'(pts_idx), 32'h0);
        checkOutput("postrst_d", pts_d, frameWord(11, 0));
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/fft_pts.md
FFT_PTS -- requirements
Module: fft_pts

Interface
REQ-001 SHALL have port CLK, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST_N, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port fft_valid, input, 1 bit: single-cycle strobe marking fft_d0..fft_d15 as a complete frame.
REQ-004 SHALL have ports fft_d0..fft_d15, input, 32 bits each: complex bins, [31:16] signed real, [15:0] signed imag.
REQ-005 SHALL have port out_ready, input, 1 bit: downstream accepts pts_d this cycle.
REQ-006 SHALL have port pts_valid, output, 1 bit: pts_d holds a valid bin.
REQ-007 SHALL have port pts_d, output, 32 bits: current bin, unmodified from input.
REQ-008 SHALL have port pts_idx, output, 4 bits: bin index of pts_d, 0..15.
REQ-009 SHALL have port pts_last, output, 1 bit: pts_valid high and pts_idx == 15.
REQ-010 SHALL have port overflow, output, 1 bit: sticky, a frame was dropped.

Function
REQ-011 SHALL hold two 16x32 frame banks (A/B) with registered full flags, write pointer wr_sel, read pointer rd_sel, index rd_idx.
REQ-012 SHALL, on fft_valid with bank[wr_sel] not full, capture all 16 inputs into bank[wr_sel] at that edge, set its full flag, toggle wr_sel.
REQ-013 SHALL treat bank[wr_sel] as free in the same cycle that bank's final handshake (rd_idx 15) occurs; the load is accepted and the full flag stays 1.
REQ-014 SHALL, on fft_valid with bank[wr_sel] full and not freed that cycle, drop the frame, leave banks and pointers unchanged, set overflow.
REQ-015 SHALL drive pts_valid = full[rd_sel]; pts_d = bank[rd_sel][rd_idx]; pts_idx = rd_idx (combinational from registers).
REQ-016 SHALL, on handshake (pts_valid && out_ready), increment rd_idx; at rd_idx 15 wrap to 0, clear full[rd_sel], toggle rd_sel.
REQ-017 SHALL hold pts_d, pts_idx, pts_valid stable while pts_valid && !out_ready.
REQ-018 SHALL give latency of exactly one cycle: fft_valid at edge N into an empty block gives pts_valid=1, pts_idx=0 in cycle after N.
REQ-019 SHALL, with out_ready held high, emit 16 consecutive bins with no bubble, and continue into the next full bank without a bubble.
REQ-020 SHALL ignore fft_d* when fft_valid is low; fft_valid high on consecutive cycles is treated as separate frames.
REQ-021 SHALL keep overflow set until reset; no other clear.
REQ-022 SHALL implement control as FSM: EMPTY (no bank full), ONE (one full), BOTH (two full); transitions by load/release per REQ-012..016, load+release same cycle keeps state.

Reset
REQ-023 SHALL, on RST_N low, asynchronously clear full flags, wr_sel, rd_sel, rd_idx, overflow; pts_valid=0, pts_idx=0, pts_last=0, pts_d=0.
REQ-024 SHALL not reset bank contents; they are unobservable while full flags are clear.
REQ-025 SHALL, on reset mid-frame, discard partial output; first post-reset frame starts at idx 0 from bank A.

Structure
REQ-026 SHALL take N_BINS=16, DATA_W=32, IDX_W=4 and FSM state type from shared package fft_pkg.
REQ-027 SHALL instantiate sub-module pts_bank twice (16x32 register array, parallel load, indexed read).

Verification
REQ-028 Single frame, bins k = {16'(k),16'(-k)}, out_ready=1 -> pts_valid 16 cycles from cycle after load, pts_idx 0..15, pts_last only at 15, values exact.
REQ-029 Two frames 3 cycles apart, out_ready=1 -> 32 contiguous valid cycles, frame 2 follows idx 15 of frame 1 with no bubble, overflow=0.
REQ-030 Three frames back-to-back cycles, out_ready=0 -> frames 1,2 held, frame 3 dropped, overflow=1; releasing ready outputs frames 1 then 2 only.
REQ-031 Both banks full, third fft_valid on the cycle frame-1 idx 15 handshakes -> frame 3 accepted, output order 1,2,3, overflow=0.
REQ-032 out_ready toggling 1010... -> each bin held until accepted, pts_d stable while stalled, order unchanged.
REQ-033 RST_N low at pts_idx 7 -> outputs zero immediately; new frame after release streams from idx 0 with correct data.
